spc_bench_memory: RTL

//  Parametrised bench memory subsystem placed between the SPC700 CPU and its RAM for simulation/FPGA test.

---
 rtl/spc_bench_memory_if.sv | 45 ++++
 rtl/spc_bench_memory.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/spc_bench_memory_if.sv
// Signal bundle between the bench memory and its CPU, host-loader and trace consumers.
// slave is the memory side; master is the side that drives CPU, host and trace inputs.
interface spc_bench_memory_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] in_cpu_address;
  logic [DATA_WIDTH-1:0] in_cpu_write;
  logic                  in_cpu_write_enable;
  logic [DATA_WIDTH-1:0] out_cpu_read;
  logic                  in_cpu_halted;
  logic                  out_cpu_hold;
  logic                  in_host_mode;
  logic                  in_host_request;
  logic                  in_host_write_enable;
  logic [ADDR_WIDTH-1:0] in_host_address;
  logic [DATA_WIDTH-1:0] in_host_write_data;
  logic                  out_host_ack;
  logic [DATA_WIDTH-1:0] out_host_read;
  logic                  out_trace_valid;
  logic                  in_trace_ready;
  logic [ADDR_WIDTH-1:0] out_trace_address;
  logic [DATA_WIDTH-1:0] out_trace_data;
  logic                  out_trace_overflow;
  logic [31:0]           out_cycle_count;
  logic                  out_timeout;

  modport slave (
    input  in_cpu_address, in_cpu_write, in_cpu_write_enable, in_cpu_halted,
    input  in_host_mode, in_host_request, in_host_write_enable, in_host_address,
    input  in_host_write_data, in_trace_ready,
    output out_cpu_read, out_cpu_hold, out_host_ack, out_host_read,
    output out_trace_valid, out_trace_address, out_trace_data, out_trace_overflow,
    output out_cycle_count, out_timeout
  );

  modport master (
    output in_cpu_address, in_cpu_write, in_cpu_write_enable, in_cpu_halted,
    output in_host_mode, in_host_request, in_host_write_enable, in_host_address,
    output in_host_write_data, in_trace_ready,
    input  out_cpu_read, out_cpu_hold, out_host_ack, out_host_read,
    input  out_trace_valid, out_trace_address, out_trace_data, out_trace_overflow,
    input  out_cycle_count, out_timeout
  );
endinterface

// File: rtl/spc_bench_memory.sv
// Bench RAM for the SPC700: latency-configurable read path, host load port that holds
// the CPU, CPU write-trace FIFO and a run-cycle counter with timeout flag.
module spc_bench_memory #(
  parameter int              ADDR_WIDTH     = 16,
  parameter int              DATA_WIDTH     = 8,
  parameter int              READ_LATENCY   = 1,
  parameter int              TRACE_DEPTH    = 16,
  parameter longint unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic               clock,
  input logic               reset,
  spc_bench_memory_if.slave bus
);
  localparam int          PW          = $clog2(TRACE_DEPTH);
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } trace_t;

  state_t                state, next_state;
  logic                  hold;
  logic                  accept;
  logic [1:0]            lat_cnt;
  logic [ADDR_WIDTH-1:0] cap_addr;

  // ---------------- host FSM ----------------
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (hold && bus.in_host_request) begin
        accept     = 1'b1;
        next_state = BUSY;
      end
      BUSY:    if (lat_cnt == 2'd0) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold     <= 1'b0;
      lat_cnt  <= 2'd0;
      cap_addr <= '0;
    end else begin
      state <= next_state;
      hold  <= bus.in_host_mode | (next_state != IDLE);
      if (accept) begin
        lat_cnt  <= 2'(READ_LATENCY - 1);
        cap_addr <= bus.in_host_address;
      end else if (state == BUSY && lat_cnt != 2'd0) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
    end
  end

  // ---------------- shared RAM port ----------------
  logic [DATA_WIDTH-1:0]                    mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0]                    ram_addr;
  logic [DATA_WIDTH-1:0]                    ram_wdata;
  logic                                     ram_we, cpu_wr;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0]  rd_pipe;
  logic [DATA_WIDTH-1:0]                    rd_out;

  // While BUSY the captured address keeps being read, so the word seen at ACK
  // already reflects a write made at accept.
  assign ram_addr  = !hold ? bus.in_cpu_address :
                     (state == IDLE) ? bus.in_host_address : cap_addr;
  assign cpu_wr    = !hold && bus.in_cpu_write_enable;
  assign ram_we    = cpu_wr || (accept && bus.in_host_write_enable);
  assign ram_wdata = hold ? bus.in_host_write_data : bus.in_cpu_write;

  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= mem[ram_addr];
      for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign rd_out            = rd_pipe[READ_LATENCY-1];
  assign bus.out_cpu_read  = rd_out;
  assign bus.out_cpu_hold  = hold;
  assign bus.out_host_ack  = (state == ACK);
  assign bus.out_host_read = (state == ACK) ? rd_out : '0;

  // ---------------- write-trace FIFO ----------------
  trace_t [TRACE_DEPTH-1:0] tr_mem;
  logic   [PW-1:0]          wr_ptr, rd_ptr, head_ptr;
  logic   [PW:0]            tr_cnt;
  logic                     tr_full, tr_valid, tr_pop, tr_push, tr_ovf;

  assign tr_full  = (tr_cnt == (PW+1)'(TRACE_DEPTH));
  assign tr_valid = (tr_cnt != '0);
  assign tr_pop   = bus.in_trace_ready && tr_valid;
  assign tr_push  = cpu_wr && (!tr_full || tr_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tr_mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      tr_cnt <= '0;
      tr_ovf <= 1'b0;
    end else begin
      if (tr_push) begin
        tr_mem[wr_ptr] <= '{addr: bus.in_cpu_address, data: bus.in_cpu_write};
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (tr_pop) rd_ptr <= rd_ptr + PW'(1);
      tr_cnt <= tr_cnt + (PW+1)'(tr_push) - (PW+1)'(tr_pop);
      if (cpu_wr && tr_full && !tr_pop) tr_ovf <= 1'b1;
    end
  end

  // When empty the slot behind the read pointer is the last entry popped.
  assign head_ptr               = tr_valid ? rd_ptr : rd_ptr - PW'(1);
  assign bus.out_trace_valid    = tr_valid;
  assign bus.out_trace_address  = tr_mem[head_ptr].addr;
  assign bus.out_trace_data     = tr_mem[head_ptr].data;
  assign bus.out_trace_overflow = tr_ovf;

  // ---------------- run counter / watchdog ----------------
  logic [31:0] cyc, cyc_nxt;
  logic        timeout;

  assign cyc_nxt = (!bus.in_cpu_halted && !hold && cyc != '1) ? cyc + 32'd1 : cyc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc     <= '0;
      timeout <= 1'b0;
    end else begin
      cyc <= cyc_nxt;
      if (cyc_nxt >= TIMEOUT_LIM) timeout <= 1'b1;
    end
  end

  assign bus.out_cycle_count = cyc;
  assign bus.out_timeout     = timeout;
endmodule
